// File: rtl/phy_lane_arbiter_if.sv
// Lane-side bus of the PHY lane arbiter: four lane words with push strobes in,
// the scheduled word with a valid/ready handshake and per-lane status out.
interface phy_lane_arbiter_if #(parameter int WIDTH = 9);
  logic [WIDTH-1:0] paralelo0;
  logic [WIDTH-1:0] paralelo1;
  logic [WIDTH-1:0] paralelo2;
  logic [WIDTH-1:0] paralelo3;
  logic [3:0]       push;
  logic             ready_in;
  logic [3:0]       full;
  logic [3:0]       overflow;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic [1:0]       lane_out;

  modport master (
    output paralelo0, paralelo1, paralelo2, paralelo3, push, ready_in,
    input  full, overflow, data_out, valid_out, lane_out
  );

  modport slave (
    input  paralelo0, paralelo1, paralelo2, paralelo3, push, ready_in,
    output full, overflow, data_out, valid_out, lane_out
  );
endinterface

// File: rtl/phy_lane_arbiter.sv
// Four lane FIFOs drained round-robin, one word per grant, into a registered
// valid/ready output. Define PHY_ARB_IDLE_EN to emit IDLE_SYM when all lanes are empty.
module phy_lane_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk4f,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             nonempty,
  output logic             full,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             wr, rd;

  // Words with the valid bit clear carry no data and are never stored.
  assign wr       = push & din[WIDTH-1] & ~full;
  assign rd       = pop & nonempty;
  assign nonempty = (count != '0);
  assign head     = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({wr, rd})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk4f) begin
    if (!reset && wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk4f) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      // full is the pre-pop view, so a push racing a pop still drops.
      if (push & din[WIDTH-1] & full) overflow <= 1'b1;
    end
  end
endmodule

module phy_lane_arbiter #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
`ifdef PHY_ARB_IDLE_EN
  , parameter logic [7:0] IDLE_SYM = 8'hBC
`endif
) (
  input  logic               clk4f,
  input  logic               reset,
  phy_lane_arbiter_if.slave  bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                            state;
  logic [NUM_LANES-1:0][WIDTH-1:0]   lane_word, lane_head;
  logic [NUM_LANES-1:0]              nonempty, pop, full_v, ovf_v;
  logic [WIDTH-1:0]                  data_q;
  logic [1:0]                        lane_q, rr_ptr, winner, idx;
  logic                              found, load;

  assign lane_word[0] = bus.paralelo0;
  assign lane_word[1] = bus.paralelo1;
  assign lane_word[2] = bus.paralelo2;
  assign lane_word[3] = bus.paralelo3;

  assign load = (state != SEND) | bus.ready_in;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign pop[i] = load & found & (winner == 2'(i));
    phy_lane_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
      .clk4f    (clk4f),
      .reset    (reset),
      .push     (bus.push[i]),
      .pop      (pop[i]),
      .din      (lane_word[i]),
      .head     (lane_head[i]),
      .nonempty (nonempty[i]),
      .full     (full_v[i]),
      .overflow (ovf_v[i])
    );
  end

  // First non-empty lane at or after rr_ptr; occupancy excludes this cycle's pushes.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = rr_ptr;
    for (int j = 0; j < NUM_LANES; j++) begin
      idx = rr_ptr + 2'(j);
      if (!found && nonempty[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk4f) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      data_q <= '0;
      lane_q <= '0;
    end else if (load) begin
      if (found) begin
        state  <= SEND;
        data_q <= lane_head[winner];
        lane_q <= winner;
        rr_ptr <= winner + 2'd1;
      end else begin
`ifdef PHY_ARB_IDLE_EN
        state  <= SEND;
        data_q <= {{(WIDTH-8){1'b0}}, IDLE_SYM};
        lane_q <= '0;
`else
        state  <= IDLE;
`endif
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.lane_out  = lane_q;
  assign bus.valid_out = (state == SEND);
  assign bus.full      = full_v;
  assign bus.overflow  = ovf_v;
endmodule

// File: tb/tb_phy_lane_arbiter.sv
// Scoreboard bench for phy_lane_arbiter: directed pushes queue {lane,word}
// expectations; a negedge monitor pops them on every accepted transfer.
module tb_phy_lane_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  phy_lane_arbiter_if #(.WIDTH(9)) bus ();
  phy_lane_arbiter #(.DEPTH(4), .WIDTH(9)) dut (
    .clk4f (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q [$];
`ifdef PHY_ARB_IDLE_EN
  logic exp_idle_valid = 1'b1;
`else
  logic exp_idle_valid = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the head of the expectation queue.
  always @(negedge clk) begin
    logic [10:0] e;
    logic        skip;
    skip = 1'b0;
    if (!reset && bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
`ifdef PHY_ARB_IDLE_EN
      if (bus.data_out === 9'h0BC) skip = 1'b1;
`endif
      if (!skip) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got lane %0d data %0h expected none",
                   bus.lane_out, bus.data_out);
        end else begin
          e = exp_q.pop_front();
          chk("scoreboard", {21'd0, bus.lane_out, bus.data_out}, {21'd0, e});
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max) begin
      step();
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  logic [8:0] t3w [5];

  initial begin
    t3w = '{9'h1FE, 9'h1FD, 9'h1FB, 9'h1FF, 9'h155};
    bus.paralelo0 = '0; bus.paralelo1 = '0; bus.paralelo2 = '0; bus.paralelo3 = '0;
    bus.push = 4'h0;
    bus.ready_in = 1'b1;
    reset = 1'b1;
    step(2);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_lane", bus.lane_out, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.overflow, 0);
    reset = 1'b0;

    // 1: one push on all lanes, drained in lane order with one-cycle latency
    bus.paralelo0 = 9'h1FF; bus.paralelo1 = 9'h1F5; bus.paralelo2 = 9'h1FA; bus.paralelo3 = 9'h1F4;
    bus.push = 4'hF;
    exp_q.push_back({2'd0, 9'h1FF}); exp_q.push_back({2'd1, 9'h1F5});
    exp_q.push_back({2'd2, 9'h1FA}); exp_q.push_back({2'd3, 9'h1F4});
    step();
    bus.push = 4'h0;
    chk("t1_push_cycle_valid", bus.valid_out, 0);
    step();
    chk("t1_first_valid", bus.valid_out, 1);
    chk("t1_first_data", bus.data_out, 9'h1FF);
    drain(20);
    chk("t1_end_valid", bus.valid_out, exp_idle_valid);

    // 2: words with valid bit clear are discarded silently
    bus.paralelo0 = 9'h0FF; bus.paralelo1 = 9'h0FF; bus.paralelo2 = 9'h1FF; bus.paralelo3 = 9'h055;
    bus.push = 4'hF;
    exp_q.push_back({2'd2, 9'h1FF});
    step();
    bus.push = 4'h0;
    drain(20);
    chk("t2_ovf", bus.overflow, 0);
    chk("t2_end_valid", bus.valid_out, exp_idle_valid);

    // 5 + 3: hold 155 under backpressure while lane 2 overfills
    bus.ready_in = 1'b0;
    bus.paralelo1 = 9'h155;
    bus.push = 4'b0010;
    exp_q.push_back({2'd1, 9'h155});
    step();
    bus.push = 4'h0;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.paralelo2 = t3w[i];
      bus.push = 4'b0100;
      if (i < 4) exp_q.push_back({2'd2, t3w[i]});
      step();
      chk("t5_hold_valid", bus.valid_out, 1);
      chk("t5_hold_data", bus.data_out, 9'h155);
      chk("t5_hold_lane", bus.lane_out, 1);
    end
    bus.push = 4'h0;
    chk("t3_full", bus.full, 4'b0100);
    chk("t3_ovf", bus.overflow, 4'b0100);
    bus.ready_in = 1'b1;
    drain(20);
    chk("t3_full_after", bus.full, 0);
    chk("t3_ovf_sticky", bus.overflow, 4'b0100);

    // 4: round-robin fairness between lanes 0 and 3 from a fresh rr_ptr
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t4_ovf_cleared", bus.overflow, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'd0, 9'h101 + 9'(i)});
      exp_q.push_back({2'd3, 9'h131 + 9'(i)});
    end
    for (int i = 0; i < 3; i++) begin
      bus.paralelo0 = 9'h101 + 9'(i);
      bus.paralelo3 = 9'h131 + 9'(i);
      bus.push = 4'b1001;
      step();
    end
    bus.push = 4'h0;
    drain(20);

    // 6: reset while a word is held and another is queued
    bus.ready_in = 1'b0;
    bus.paralelo0 = 9'h1AA; bus.paralelo1 = 9'h1BB;
    bus.push = 4'b0011;
    step();
    bus.push = 4'h0;
    step();
    chk("t6_pre_valid", bus.valid_out, 1);
    reset = 1'b1;
    step();
    chk("t6_rst_valid", bus.valid_out, 0);
    chk("t6_rst_data", bus.data_out, 0);
    chk("t6_rst_lane", bus.lane_out, 0);
    chk("t6_rst_full", bus.full, 0);
    reset = 1'b0;
    bus.ready_in = 1'b1;
    step(5);
    chk("t6_post_valid", bus.valid_out, exp_idle_valid);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
